// File: rtl/intr_if.sv
// Bus between the interrupt controller and its environment (config port,
// fetch request/ack handshake, raw sources and a debug view of the FSM state).
interface intr_if;
  logic [3:0]  irq_raw;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        int_ack;
  logic        rti;
  logic [3:0]  int_req;
  logic [1:0]  active_id;
  logic        busy;
  logic [1:0]  state;

  modport master (
    output irq_raw, cfg_we, cfg_addr, cfg_wdata, int_ack, rti,
    input  cfg_rdata, int_req, active_id, busy, state
  );

  modport slave (
    input  irq_raw, cfg_we, cfg_addr, cfg_wdata, int_ack, rti,
    output cfg_rdata, int_req, active_id, busy, state
  );
endinterface

// File: rtl/intr_ctrl.sv
// Four-source fixed-priority interrupt controller with synchronised inputs,
// per-source edge/level mode, W1C pending register and an IDLE/REQ/SERVICE FSM.
module intr_ctrl (
  input  logic   clk,
  input  logic   reset,
  intr_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

  state_t     state;
  logic [3:0] s1, s2, s3;
  logic [3:0] mask, mode, pending;
  logic [3:0] eligible, set_vec, w1c_vec, ack_clr, winner_oh;
  logic [1:0] winner_id;
  logic [3:0] int_req;
  logic [1:0] active_id;
  logic       ack_taken;

  assign eligible  = pending & mask;
  assign set_vec   = (mode & s2 & ~s3) | (~mode & s2);
  assign w1c_vec   = (bus.cfg_we && bus.cfg_addr == 2'd1) ? bus.cfg_wdata[3:0] : 4'h0;
  assign ack_taken = (state == REQ) && bus.int_ack;
  assign ack_clr   = ack_taken ? (4'b0001 << active_id) : 4'h0;

  // Handshake: int_req is held one-hot until fetch pulses int_ack (taken) or
  // the latched source stops being eligible (withdrawn); never switches REQ->REQ.
  always_comb begin
    winner_id = 2'd0;
    winner_oh = 4'b0000;
    if (eligible[0]) begin
      winner_id = 2'd0; winner_oh = 4'b0001;
    end else if (eligible[1]) begin
      winner_id = 2'd1; winner_oh = 4'b0010;
    end else if (eligible[2]) begin
      winner_id = 2'd2; winner_oh = 4'b0100;
    end else if (eligible[3]) begin
      winner_id = 2'd3; winner_oh = 4'b1000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s1        <= 4'h0;
      s2        <= 4'h0;
      s3        <= 4'h0;
      mask      <= 4'hF;
      mode      <= 4'hF;
      pending   <= 4'h0;
      int_req   <= 4'h0;
      active_id <= 2'd0;
    end else begin
      s1 <= bus.irq_raw;
      s2 <= s1;
      s3 <= s2;
      if (bus.cfg_we && bus.cfg_addr == 2'd0) mask <= bus.cfg_wdata[3:0];
      if (bus.cfg_we && bus.cfg_addr == 2'd2) mode <= bus.cfg_wdata[3:0];
      // New sets beat a same-cycle W1C; the ack clear beats everything.
      pending <= ((pending & ~w1c_vec) | set_vec) & ~ack_clr;
      case (state)
        IDLE: begin
          if (eligible != 4'h0) begin
            state     <= REQ;
            active_id <= winner_id;
            int_req   <= winner_oh;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            state   <= SERVICE;
            int_req <= 4'h0;
          end else if (!eligible[active_id]) begin
            state   <= IDLE;
            int_req <= 4'h0;
          end
        end
        SERVICE: begin
          if (bus.rti) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          int_req <= 4'h0;
        end
      endcase
    end
  end

  always_comb begin
    bus.cfg_rdata = 32'h0;
    case (bus.cfg_addr)
      2'd0:    bus.cfg_rdata[3:0] = mask;
      2'd1:    bus.cfg_rdata[3:0] = pending;
      2'd2:    bus.cfg_rdata[3:0] = mode;
      default: bus.cfg_rdata[5:0] = {state != IDLE, state == SERVICE, active_id,
                                     eligible != 4'h0, 1'b0};
    endcase
  end

  assign bus.int_req   = int_req;
  assign bus.active_id = active_id;
  assign bus.busy      = (state != IDLE);
  assign bus.state     = state;
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: a request scoreboard checked by a monitor on
// every new int_req, plus cycle-exact register and output checks.
module tb_intr_ctrl;
  logic clk;
  logic reset;
  intr_if bus ();

  intr_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int passed = 0;
  logic [5:0] exp_q[$];
  logic [3:0] prev_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.cfg_addr = a;
    #1;
    chk(name, bus.cfg_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    tick(1);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.int_ack = 1'b1;
    tick(1);
    bus.int_ack = 1'b0;
  endtask

  task automatic rti_pulse();
    bus.rti = 1'b1;
    tick(1);
    bus.rti = 1'b0;
  endtask

  // monitor: every fresh request is matched against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      prev_req <= 4'h0;
    end else begin
      if (bus.int_req != 4'h0 && prev_req == 4'h0) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_req: got id=%0d req=%b, expected none",
                   bus.active_id, bus.int_req);
        end else begin
          chk("req_seq", {26'h0, bus.active_id, bus.int_req}, {26'h0, exp_q.pop_front()});
        end
      end
      prev_req <= bus.int_req;
    end
  end

  initial begin
    bus.irq_raw = 4'h0; bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = 32'h0;
    bus.int_ack = 1'b0; bus.rti = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    chk("rst_int_req", {28'h0, bus.int_req}, 32'h0);
    rd_chk("rst_status", 2'd3, 32'h0);
    rd_chk("rst_mask", 2'd0, 32'hF);
    tick(1);
    rd_chk("rst_mode", 2'd2, 32'hF);
    rd_chk("rst_pending", 2'd1, 32'h0);

    // single edge source, latency
    bus.irq_raw = 4'b0100;
    exp_q.push_back({2'd2, 4'b0100});
    tick(2);
    rd_chk("lat_pend_early", 2'd1, 32'h0);
    tick(1);
    rd_chk("lat_pend", 2'd1, 32'h4);
    chk("lat_req_early", {28'h0, bus.int_req}, 32'h0);
    tick(1);
    chk("lat_req", {28'h0, bus.int_req}, 32'h4);
    chk("lat_id", {30'h0, bus.active_id}, 32'd2);
    tick(1);
    ack_pulse();
    chk("ack_req0", {28'h0, bus.int_req}, 32'h0);
    chk("ack_busy", {31'h0, bus.busy}, 32'h1);
    rd_chk("ack_pend", 2'd1, 32'h0);
    rd_chk("svc_status", 2'd3, 32'h38);
    bus.irq_raw = 4'h0;
    ack_pulse();
    chk("svc_ack_ignored", {31'h0, bus.busy}, 32'h1);
    rti_pulse();
    chk("rti_busy", {31'h0, bus.busy}, 32'h0);

    // fixed priority
    tick(2);
    bus.irq_raw = 4'b1010;
    exp_q.push_back({2'd1, 4'b0010});
    exp_q.push_back({2'd3, 4'b1000});
    tick(4);
    chk("prio_req", {28'h0, bus.int_req}, 32'h2);
    bus.irq_raw = 4'h0;
    ack_pulse();
    rti_pulse();
    tick(1);
    chk("prio_req2", {28'h0, bus.int_req}, 32'h8);
    ack_pulse();
    rti_pulse();

    // mask withdrawal during REQ, higher priority does not preempt
    tick(2);
    bus.irq_raw = 4'b1001;
    exp_q.push_back({2'd0, 4'b0001});
    exp_q.push_back({2'd3, 4'b1000});
    tick(4);
    chk("mask_req", {28'h0, bus.int_req}, 32'h1);
    bus.irq_raw = 4'h0;
    wr(2'd0, 32'hFFFF_FFFE);
    chk("mask_still_req", {28'h0, bus.int_req}, 32'h1);
    tick(1);
    chk("mask_idle_req", {28'h0, bus.int_req}, 32'h0);
    chk("mask_idle_busy", {31'h0, bus.busy}, 32'h0);
    tick(1);
    chk("mask_rearb", {28'h0, bus.int_req}, 32'h8);
    ack_pulse();
    rti_pulse();
    rd_chk("mask_pend", 2'd1, 32'h1);
    wr(2'd1, 32'h1);
    rd_chk("w1c_clear", 2'd1, 32'h0);
    wr(2'd0, 32'hF);

    // W1C colliding with a new bit0 edge
    tick(2);
    bus.irq_raw = 4'b0001;
    exp_q.push_back({2'd0, 4'b0001});
    tick(2);
    wr(2'd1, 32'h1);
    rd_chk("w1c_collide", 2'd1, 32'h1);
    tick(1);
    bus.irq_raw = 4'h0;
    ack_pulse();
    rti_pulse();

    // level mode, re-pend after ack
    tick(2);
    wr(2'd2, 32'h0);
    bus.irq_raw = 4'b0010;
    exp_q.push_back({2'd1, 4'b0010});
    exp_q.push_back({2'd1, 4'b0010});
    tick(4);
    chk("lvl_req", {28'h0, bus.int_req}, 32'h2);
    ack_pulse();
    rd_chk("lvl_ack_clr", 2'd1, 32'h0);
    tick(1);
    rd_chk("lvl_repend", 2'd1, 32'h2);
    rti_pulse();
    tick(1);
    chk("lvl_req_again", {28'h0, bus.int_req}, 32'h2);
    bus.irq_raw = 4'h0;
    tick(3);
    ack_pulse();
    rti_pulse();
    tick(2);
    rd_chk("lvl_pend_final", 2'd1, 32'h0);
    wr(2'd2, 32'hF);

    // same-cycle ack+rti in REQ, then reset in SERVICE
    tick(2);
    bus.irq_raw = 4'b0001;
    exp_q.push_back({2'd0, 4'b0001});
    tick(4);
    bus.irq_raw = 4'h0;
    bus.int_ack = 1'b1;
    bus.rti     = 1'b1;
    tick(1);
    bus.int_ack = 1'b0;
    bus.rti     = 1'b0;
    rd_chk("ackrti_status", 2'd3, 32'h30);
    reset         = 1'b1;
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 2'd0;
    bus.cfg_wdata = 32'h0;
    bus.int_ack   = 1'b1;
    tick(1);
    reset       = 1'b0;
    bus.cfg_we  = 1'b0;
    bus.int_ack = 1'b0;
    rd_chk("rstsvc_status", 2'd3, 32'h0);
    rd_chk("rstsvc_mask", 2'd0, 32'hF);
    rd_chk("rstsvc_pend", 2'd1, 32'h0);
    ack_pulse();
    chk("rstsvc_ack_req", {28'h0, bus.int_req}, 32'h0);
    chk("rstsvc_ack_busy", {31'h0, bus.busy}, 32'h0);

    tick(4);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
